// File: rtl/legv8_control_fsm_if.sv
// Bundle of the signals between the LEGv8 datapath and its multi-cycle control unit.
// The datapath (master) supplies IR/status/mem_ready; the control unit (slave) returns its drives.
interface legv8_control_fsm_if;
  logic [31:0] IR;
  logic [3:0]  status;
  logic        mem_ready;
  logic [35:0] controlWord;
  logic [31:0] k;
  logic [2:0]  state;
  logic        halted;

  modport master (
    output IR, status, mem_ready,
    input  controlWord, k, state, halted
  );

  modport slave (
    input  IR, status, mem_ready,
    output controlWord, k, state, halted
  );
endinterface

// File: rtl/legv8_control_fsm.sv
// Multi-cycle LEGv8 control unit: sequences fetch/execute/memory/branch cycles and drives
// the datapath control word and constant combinationally from the registered state.
module legv8_control_fsm (
  input  logic              clock,
  input  logic              reset,
  legv8_control_fsm_if.slave bus
);

  localparam logic [4:0] FS_AND = 5'b00000;
  localparam logic [4:0] FS_ORR = 5'b00100;
  localparam logic [4:0] FS_ADD = 5'b01000;
  localparam logic [4:0] FS_SUB = 5'b01001;
  localparam logic [4:0] ZR     = 5'd31;

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] EXEC   = 3'd1;
  localparam logic [2:0] MEM    = 3'd2;
  localparam logic [2:0] BRANCH = 3'd3;
  localparam logic [2:0] HALT   = 3'd4;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;
  localparam logic [7:0]  OP_CBZ  = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ = 8'b10110101;
  localparam logic [5:0]  OP_B    = 6'b000101;

  logic [31:0] ir;
  logic        mem_ready;
  logic        zero_flag;
  logic        unused_status;

  assign ir            = bus.IR;
  assign mem_ready     = bus.mem_ready;
  assign zero_flag     = bus.status[0];
  assign unused_status = ^bus.status[3:1];

  logic [2:0] state_q;
  logic [2:0] state_next;

  logic is_add, is_sub, is_and, is_orr, is_addi, is_subi;
  logic is_rtype, is_itype, is_ldur, is_stur, is_cbz, is_cbnz, is_b;
  logic [4:0] alu_fs;
  logic [4:0] rn, rm, rd;

  assign is_add   = (ir[31:21] == OP_ADD);
  assign is_sub   = (ir[31:21] == OP_SUB);
  assign is_and   = (ir[31:21] == OP_AND);
  assign is_orr   = (ir[31:21] == OP_ORR);
  assign is_addi  = (ir[31:22] == OP_ADDI);
  assign is_subi  = (ir[31:22] == OP_SUBI);
  assign is_ldur  = (ir[31:21] == OP_LDUR);
  assign is_stur  = (ir[31:21] == OP_STUR);
  assign is_cbz   = (ir[31:24] == OP_CBZ);
  assign is_cbnz  = (ir[31:24] == OP_CBNZ);
  assign is_b     = (ir[31:26] == OP_B);
  assign is_rtype = is_add | is_sub | is_and | is_orr;
  assign is_itype = is_addi | is_subi;

  assign alu_fs = (is_sub | is_subi) ? FS_SUB :
                  is_and             ? FS_AND :
                  is_orr             ? FS_ORR : FS_ADD;

  assign rn = ir[9:5];
  assign rm = ir[20:16];
  assign rd = ir[4:0];

  always_ff @(posedge clock) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_next;
  end

  logic [4:0]  fs, sa, sb, da;
  logic        w_reg, c0, mem_cs, b_sel, mem_w, ir_load, status_load;
  logic [1:0]  size;
  logic        add_tri_sel;
  logic [1:0]  data_tri_sel;
  logic        pc_sel;
  logic [1:0]  pc_fs;
  logic [31:0] k_val;
  logic        taken;

  always_comb begin
    fs           = FS_ADD;
    sa           = ZR;
    sb           = ZR;
    da           = ZR;
    w_reg        = 1'b0;
    c0           = 1'b0;
    mem_cs       = 1'b0;
    b_sel        = 1'b0;
    mem_w        = 1'b0;
    ir_load      = 1'b0;
    status_load  = 1'b0;
    size         = 2'b11;
    add_tri_sel  = 1'b0;
    data_tri_sel = 2'd0;
    pc_sel       = 1'b0;
    pc_fs        = 2'b00;
    k_val        = 32'd0;
    taken        = 1'b0;
    state_next   = state_q;

    case (state_q)
      FETCH: begin
        add_tri_sel  = 1'b1;
        data_tri_sel = 2'd3;
        mem_cs       = 1'b1;
        size         = 2'b10;
        ir_load      = mem_ready;
        state_next   = mem_ready ? EXEC : FETCH;
      end

      EXEC: begin
        if (is_rtype || is_itype) begin
          fs         = alu_fs;
          c0         = is_sub | is_subi;
          sa         = rn;
          sb         = rm;
          da         = rd;
          w_reg      = 1'b1;
          pc_fs      = 2'b01;
          state_next = FETCH;
          if (is_itype) begin
            b_sel = 1'b1;
            k_val = {20'd0, ir[21:10]};
          end
        end else if (is_ldur || is_stur) begin
          state_next = MEM;
        end else if (is_cbz || is_cbnz) begin
          sb          = rd;
          status_load = 1'b1;
          state_next  = BRANCH;
        end else if (is_b) begin
          pc_sel     = 1'b1;
          pc_fs      = 2'b10;
          k_val      = {{6{ir[25]}}, ir[25:0]};
          state_next = FETCH;
        end else begin
          state_next = HALT;
        end
      end

      // Address is Rn + imm9; drives are held unchanged while memory is not ready.
      MEM: begin
        sa     = rn;
        b_sel  = 1'b1;
        k_val  = {{23{ir[20]}}, ir[20:12]};
        mem_cs = 1'b1;
        if (is_ldur) begin
          data_tri_sel = 2'd3;
          da           = rd;
          w_reg        = mem_ready;
        end else begin
          sb           = rd;
          data_tri_sel = 2'd1;
          mem_w        = 1'b1;
        end
        if (mem_ready) begin
          pc_fs      = 2'b01;
          state_next = FETCH;
        end
      end

      BRANCH: begin
        taken = (is_cbz & zero_flag) | (is_cbnz & ~zero_flag);
        if (taken) begin
          pc_sel = 1'b1;
          pc_fs  = 2'b10;
          k_val  = {{13{ir[23]}}, ir[23:5]};
        end else begin
          pc_fs = 2'b01;
        end
        state_next = FETCH;
      end

      HALT: state_next = HALT;

      default: state_next = FETCH;
    endcase
  end

  assign bus.controlWord = {1'b0, fs, sa, sb, da, w_reg, c0, mem_cs, b_sel, mem_w, ir_load,
                            status_load, size, add_tri_sel, data_tri_sel, pc_sel, pc_fs};
  assign bus.k      = k_val;
  assign bus.state  = state_q;
  assign bus.halted = (state_q == HALT);

endmodule
